// File: rtl/life_pkg.sv
// life_pkg
// Shared types and constants for the life_sequencer control block.
//   life_state_t : sequencer FSM states (IDLE, INIT, SWEEP)
//   PH_*         : meaning of each of the four cycles in a memory slot
//   LIFE_ROWS    : number of rows in the engine memory
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SWEEP
    } life_state_t;

    localparam logic [1:0] PH_READ  = 2'd0;
    localparam logic [1:0] PH_WRITE = 2'd1;
    localparam logic [1:0] PH_DISP  = 2'd2;
    localparam logic [1:0] PH_LD    = 2'd3;

    localparam int LIFE_ROWS = 256;

endpackage

// File: rtl/life_sequencer.sv
// life_sequencer
// Control sequencer for life_engine in the clk4 domain. Runs init sweeps,
// in-place generation sweeps and stolen-cycle display reads.
// Ports:
//   clk, reset              : engine clock, synchronous active-high reset
//   start_init, run, step   : operation requests (pulse, level, pulse)
//   disp_req, disp_row      : display read request and its row
//   disp_ack                : pulse, engine dout holds the requested row
//   raddr, waddr, re, we    : engine memory read/write control
//   ld, init                : engine dout load, write-data select
//   busy, gen_done          : status (INIT/SWEEP active, end of generation)
//   gen_count               : completed generations
module life_sequencer
    import life_pkg::*;
#(
    parameter int ROWS  = LIFE_ROWS,
    parameter int ABITS = 8,
    parameter int GBITS = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_init,
    input  logic             run,
    input  logic             step,
    input  logic             disp_req,
    input  logic [ABITS-1:0] disp_row,
    output logic             disp_ack,
    output logic [ABITS-1:0] raddr,
    output logic [ABITS-1:0] waddr,
    output logic             re,
    output logic             we,
    output logic             ld,
    output logic             init,
    output logic             busy,
    output logic             gen_done,
    output logic [GBITS-1:0] gen_count
);

    // Slot counter needs one extra bit to reach the drain slot (k = ROWS).
    localparam int CBITS = ABITS + 1;
    localparam logic [CBITS-1:0] LAST_ROW = CBITS'(ROWS - 1);
    localparam logic [CBITS-1:0] DRAIN    = CBITS'(ROWS);
    localparam logic [CBITS-1:0] FIRST_WR = CBITS'(3);

    life_state_t      state, state_n;
    logic [1:0]       phase, phase_n;
    logic [CBITS-1:0] cnt, cnt_n;
    logic             init_pend, init_pend_n;
    logic             step_pend, step_pend_n;
    logic             disp_pend, disp_pend_n;
    logic             disp_act, disp_act_n;
    logic [ABITS-1:0] disp_row_q, disp_row_n;

    logic [ABITS-1:0] raddr_n, waddr_n;
    logic             re_n, we_n, ld_n, init_n, busy_n, gen_done_n, disp_ack_n;
    logic [GBITS-1:0] gen_count_n;

    // Every output is registered and describes the cycle being entered, so
    // the next-state logic also computes the outputs from the next state,
    // next slot count and next phase.
    always_comb begin
        phase_n     = phase + 2'd1;
        state_n     = state;
        cnt_n       = cnt;
        init_pend_n = init_pend | start_init;
        step_pend_n = step_pend | step;
        gen_done_n  = 1'b0;
        gen_count_n = gen_count;

        case (state)
            IDLE: begin
                if (start_init || init_pend) begin
                    state_n     = INIT;
                    cnt_n       = '0;
                    init_pend_n = 1'b0;
                end else if (phase == PH_LD && (run || step || step_pend)) begin
                    state_n     = SWEEP;
                    cnt_n       = '0;
                    step_pend_n = 1'b0;
                end
            end
            INIT: begin
                if (cnt == LAST_ROW) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CBITS'(1);
                end
            end
            SWEEP: begin
                if (phase == PH_LD) begin
                    if (cnt == DRAIN) begin
                        // End of generation: the exit happens at phase 3, so
                        // a continuing sweep starts its first read next cycle.
                        gen_done_n  = 1'b1;
                        gen_count_n = gen_count + GBITS'(1);
                        step_pend_n = 1'b0;
                        cnt_n       = '0;
                        if (!(start_init || init_pend) && (run || step || step_pend)) begin
                            state_n = SWEEP;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CBITS'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        raddr_n     = '0;
        waddr_n     = '0;
        re_n        = 1'b0;
        we_n        = 1'b0;
        init_n      = 1'b0;
        ld_n        = 1'b0;
        disp_ack_n  = 1'b0;
        disp_pend_n = disp_pend | disp_req;
        disp_row_n  = disp_req ? disp_row : disp_row_q;
        disp_act_n  = disp_act;

        if (state_n == INIT) begin
            we_n    = 1'b1;
            init_n  = 1'b1;
            waddr_n = cnt_n[ABITS-1:0];
        end

        // Row k-2 is written one phase after read k, by which time the engine
        // holds reads k-3..k-1 and its write data is valid. Borders stay frozen.
        if (state_n == SWEEP) begin
            if (phase_n == PH_READ && cnt_n <= LAST_ROW) begin
                re_n    = 1'b1;
                raddr_n = cnt_n[ABITS-1:0];
            end
            if (phase_n == PH_WRITE && cnt_n >= FIRST_WR) begin
                we_n    = 1'b1;
                waddr_n = ABITS'(cnt_n - CBITS'(2));
            end
        end

        // Display read steals phases 2/3 with re=0 so the engine row pipeline
        // is untouched. The request is taken on entry to phase 2; anything
        // arriving after that stays pending for the following slot.
        case (phase_n)
            PH_DISP: begin
                if (disp_pend || disp_req) begin
                    raddr_n     = disp_row_n;
                    disp_act_n  = 1'b1;
                    disp_pend_n = 1'b0;
                end
            end
            PH_LD: begin
                ld_n = disp_act;
            end
            PH_READ: begin
                disp_ack_n = disp_act;
                disp_act_n = 1'b0;
            end
            default: begin
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset aborts any operation immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= 2'd0;
            cnt        <= '0;
            init_pend  <= 1'b0;
            step_pend  <= 1'b0;
            disp_pend  <= 1'b0;
            disp_act   <= 1'b0;
            disp_row_q <= '0;
            raddr      <= '0;
            waddr      <= '0;
            re         <= 1'b0;
            we         <= 1'b0;
            ld         <= 1'b0;
            init       <= 1'b0;
            busy       <= 1'b0;
            gen_done   <= 1'b0;
            gen_count  <= '0;
            disp_ack   <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            cnt        <= cnt_n;
            init_pend  <= init_pend_n;
            step_pend  <= step_pend_n;
            disp_pend  <= disp_pend_n;
            disp_act   <= disp_act_n;
            disp_row_q <= disp_row_n;
            raddr      <= raddr_n;
            waddr      <= waddr_n;
            re         <= re_n;
            we         <= we_n;
            ld         <= ld_n;
            init       <= init_n;
            busy       <= busy_n;
            gen_done   <= gen_done_n;
            gen_count  <= gen_count_n;
            disp_ack   <= disp_ack_n;
        end
    end

endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer
// Directed self-checking bench for life_sequencer: reset, init sweep,
// stepped and free-running generation sweeps, display reads, reset abort
// and init-over-run priority.
module tb_life_sequencer;

    logic        clk = 1'b0;
    logic        reset, start_init, run, step, disp_req;
    logic [7:0]  disp_row;
    logic        disp_ack, re, we, ld, init, busy, gen_done;
    logic [7:0]  raddr, waddr;
    logic [47:0] gen_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          border_hits = 0;
    logic [1:0]  ph = 2'd0;

    always #5 clk = ~clk;

    life_sequencer #(.ROWS(256), .ABITS(8), .GBITS(48)) dut (
        .clk(clk), .reset(reset), .start_init(start_init), .run(run),
        .step(step), .disp_req(disp_req), .disp_row(disp_row),
        .disp_ack(disp_ack), .raddr(raddr), .waddr(waddr), .re(re), .we(we),
        .ld(ld), .init(init), .busy(busy), .gen_done(gen_done),
        .gen_count(gen_count)
    );

    // Cycle counter and an independent model of the free-running slot phase.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ph  <= reset ? 2'd0 : ph + 2'd1;
    end

    // Generation writes must never touch the frozen border rows.
    always @(negedge clk) begin
        if (reset === 1'b0 && we === 1'b1 && init === 1'b0 &&
            (waddr === 8'h00 || waddr === 8'hFF))
            border_hits++;
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_for_re(input string tag, input int budget);
        for (int i = 0; i < budget && re !== 1'b1; i++) next_cycle();
        check_output(tag, {63'd0, re}, 64'd1);
    endtask

    task automatic wait_for_phase(input logic [1:0] p);
        for (int i = 0; i < 4 && ph != p; i++) next_cycle();
    endtask

    // Follows one generation sweep starting at its first read cycle and
    // ending on its gen_done cycle. Optionally injects a step pulse and a
    // pair of display requests (the second one during the first's ld cycle).
    task automatic run_sweep(input int step_at, input int disp_at, input logic [47:0] exp_gen);
        int t0, exp_r, exp_w;
        bit done;
        t0 = cyc; exp_r = 0; exp_w = 1; done = 1'b0;
        check_output("sweep_start_phase", {62'd0, ph}, 64'd0);
        for (int n = 0; n < 1100 && !done; n++) begin
            if (re === 1'b1) begin
                check_output("sweep_raddr", {56'd0, raddr}, 64'(exp_r));
                exp_r++;
            end
            if (we === 1'b1) begin
                check_output("sweep_waddr", {56'd0, waddr}, 64'(exp_w));
                exp_w++;
            end
            if (disp_at >= 0) begin
                if (n == disp_at + 1) begin
                    check_output("disp_raddr", {56'd0, raddr}, 64'h40);
                    check_output("disp_re", {63'd0, re}, 64'd0);
                end
                if (n == disp_at + 2) check_output("disp_ld", {63'd0, ld}, 64'd1);
                if (n == disp_at + 3) check_output("disp_ack", {63'd0, disp_ack}, 64'd1);
                if (n == disp_at + 4) check_output("disp_ack_width", {63'd0, disp_ack}, 64'd0);
                if (n == disp_at + 5) check_output("disp2_raddr", {56'd0, raddr}, 64'h11);
                if (n == disp_at + 6) check_output("disp2_ld", {63'd0, ld}, 64'd1);
                if (n == disp_at + 7) check_output("disp2_ack", {63'd0, disp_ack}, 64'd1);
            end
            step     = (n == step_at);
            disp_req = (disp_at >= 0) && (n == disp_at || n == disp_at + 2);
            disp_row = (n == disp_at) ? 8'h40 : 8'h11;
            next_cycle();
            if (gen_done === 1'b1) done = 1'b1;
        end
        step = 1'b0;
        disp_req = 1'b0;
        check_output("gen_done_seen", {63'd0, done}, 64'd1);
        check_output("sweep_length", 64'(cyc - t0), 64'd1028);
        check_output("rows_read", 64'(exp_r), 64'd256);
        check_output("rows_written", 64'(exp_w), 64'd255);
        check_output("gen_count", {16'd0, gen_count}, {16'd0, exp_gen});
    endtask

    // Idle display read issued at a given phase; checks latency and row.
    task automatic disp_latency(input logic [1:0] at_ph, input int exp_lat, input logic [7:0] row);
        int t0;
        bit saw;
        saw = 1'b0;
        wait_for_phase(at_ph);
        t0 = cyc;
        disp_req = 1'b1;
        disp_row = row;
        next_cycle();
        disp_req = 1'b0;
        for (int i = 0; i < 10 && disp_ack !== 1'b1; i++) begin
            if (ph == 2'd2 && re === 1'b0 && raddr === row) saw = 1'b1;
            next_cycle();
        end
        check_output("disp_latency", 64'(cyc - t0), 64'(exp_lat));
        check_output("disp_idle_row", {63'd0, saw}, 64'd1);
    endtask

    task automatic apply_stimulus();
        // Reset: all outputs zero.
        reset = 1'b1; start_init = 1'b0; run = 1'b0; step = 1'b0;
        disp_req = 1'b0; disp_row = 8'h00;
        repeat (3) next_cycle();
        check_output("rst_we", {63'd0, we}, 64'd0);
        check_output("rst_re", {63'd0, re}, 64'd0);
        check_output("rst_busy", {63'd0, busy}, 64'd0);
        check_output("rst_gen_count", {16'd0, gen_count}, 64'd0);
        check_output("rst_addr", {48'd0, raddr, waddr}, 64'd0);
        check_output("rst_misc", {60'd0, ld, init, gen_done, disp_ack}, 64'd0);
        reset = 1'b0;
        next_cycle();

        // Init sweep: 256 write cycles starting the cycle after the pulse.
        start_init = 1'b1;
        next_cycle();
        start_init = 1'b0;
        for (int i = 0; i < 256; i++) begin
            check_output("init_waddr", {56'd0, waddr}, 64'(i));
            check_output("init_we_init_re_busy", {60'd0, we, init, re, busy}, 64'hD);
            next_cycle();
        end
        check_output("init_end_busy", {63'd0, busy}, 64'd0);
        check_output("init_end_we", {63'd0, we}, 64'd0);

        // Single step, with a second step latched mid-sweep.
        step = 1'b1;
        next_cycle();
        step = 1'b0;
        wait_for_re("step_first_re", 8);
        run_sweep(200, -1, 48'd1);
        check_output("step_chain_re", {63'd0, re}, 64'd1);
        run_sweep(-1, -1, 48'd2);
        check_output("step_end_busy", {63'd0, busy}, 64'd0);
        next_cycle();
        check_output("gen_done_width", {63'd0, gen_done}, 64'd0);
        repeat (8) next_cycle();
        check_output("step_no_extra_gen", {62'd0, re, busy}, 64'd0);

        // Idle display reads at each request phase: latency 3..6.
        disp_latency(2'd1, 3, 8'h21);
        disp_latency(2'd2, 6, 8'h22);
        disp_latency(2'd3, 5, 8'h23);
        disp_latency(2'd0, 4, 8'h24);

        // Run for three generations, display traffic in the middle one.
        run = 1'b1;
        wait_for_re("run_first_re", 8);
        run_sweep(-1, -1, 48'd3);
        run_sweep(-1, 401, 48'd4);
        run = 1'b0;
        run_sweep(-1, -1, 48'd5);
        check_output("run_end_idle", {62'd0, re, busy}, 64'd0);

        // Reset in slot 100 aborts the sweep.
        step = 1'b1;
        next_cycle();
        step = 1'b0;
        wait_for_re("abort_first_re", 8);
        repeat (400) next_cycle();
        check_output("abort_in_sweep", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check_output("abort_we_re", {62'd0, we, re}, 64'd0);
        check_output("abort_busy", {63'd0, busy}, 64'd0);
        check_output("abort_gen_count", {16'd0, gen_count}, 64'd0);

        // start_init and run together at phase 3: INIT wins.
        next_cycle();
        wait_for_phase(2'd3);
        start_init = 1'b1;
        run = 1'b1;
        next_cycle();
        start_init = 1'b0;
        run = 1'b0;
        check_output("prio_we_init_re", {61'd0, we, init, re}, 64'h6);
        check_output("prio_busy_waddr", {55'd0, busy, waddr}, 64'h100);
        repeat (256) next_cycle();
        check_output("prio_end_idle", {62'd0, re, busy}, 64'd0);
    endtask

    task automatic check_output_summary();
        check_output("border_rows_written", 64'(border_hits), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        $display("[TB] life_sequencer directed test");
        apply_stimulus();
        check_output_summary();
        $finish;
    end

endmodule
